etcpu_bpred: RTL and testbench

- Parametrised dynamic branch predictor for the etcpu fetch stage. It replaces the fixed fall-through prediction that is currently carried down the pipe as branch_taken / branch_nt_pc.
- Direct-mapped branch target buffer (BTB), one 2-bit saturating counter per entry.
- Looked up combinationally with the fetch PC. Trained by the execute stage when a branch resolves. Also keeps saturating performance counters.

---
 rtl/etcpu_bpred.sv | 130 +++++++++++++
 tb/tb_etcpu_bpred.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/etcpu_bpred.sv
// etcpu_bpred: direct-mapped branch target buffer with 2-bit direction counters.
// Combinational lookup from fetch, sequential training from execute, saturating perf counters.
module etcpu_bpred #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  lkp_pc,
    output logic             lkp_hit,
    output logic             lkp_taken,
    output logic [XLEN-1:0]  lkp_next_pc,
    input  logic             upd_vld,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispred,
    input  logic             inv,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TGT_W = XLEN - 2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("etcpu_bpred: DEPTH must be a power of two and at least 2");
    end
    if (IDX_W + 2 + TAG_W > XLEN) begin : g_bad_tag
        $error("etcpu_bpred: IDX_W + 2 + TAG_W exceeds XLEN");
    end

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] tgt;
        logic [1:0]       ctr;
    } entry_t;

    entry_t btb_q [DEPTH];

    // Lookup: reads registered state only, so a same-cycle update is never bypassed.
    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    entry_t           lkp_e;

    assign lkp_idx     = lkp_pc[IDX_W+1:2];
    assign lkp_tag     = lkp_pc[IDX_W+2 +: TAG_W];
    assign lkp_e       = btb_q[lkp_idx];
    assign lkp_hit     = lkp_e.valid && (lkp_e.tag == lkp_tag);
    assign lkp_taken   = lkp_hit && lkp_e.ctr[1];
    assign lkp_next_pc = lkp_taken ? {lkp_e.tgt, 2'b00} : lkp_pc + XLEN'(4);

    // Training: next contents of the indexed entry and whether it is written.
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_cur;
    entry_t           upd_e;
    logic             upd_hit;
    logic             upd_we;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];
    assign upd_cur = btb_q[upd_idx];
    assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

    always_comb begin
        upd_e  = upd_cur;
        upd_we = 1'b0;
        if (upd_hit) begin
            upd_we = 1'b1;
            if (upd_taken) begin
                if (upd_cur.ctr != 2'b11) begin
                    upd_e.ctr = upd_cur.ctr + 2'd1;
                end
                upd_e.tgt = upd_target[XLEN-1:2];
            end else if (upd_cur.ctr != 2'b00) begin
                upd_e.ctr = upd_cur.ctr - 2'd1;
            end
        end else if (upd_taken) begin
            // Miss on a taken branch allocates, weakly taken.
            upd_we      = 1'b1;
            upd_e.valid = 1'b1;
            upd_e.tag   = upd_tag;
            upd_e.tgt   = upd_target[XLEN-1:2];
            upd_e.ctr   = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                btb_q[IDX_W'(i)] <= '{valid: 1'b0, tag: '0, tgt: '0, ctr: CTR_INIT};
            end
        end else if (inv) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                btb_q[IDX_W'(i)].valid <= 1'b0;
            end
        end else if (upd_vld && upd_we) begin
            btb_q[upd_idx] <= upd_e;
        end
    end

    // Saturating performance counters; clear takes priority over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (perf_clr) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (upd_vld) begin
            if (perf_branches != '1) begin
                perf_branches <= perf_branches + CNT_W'(1);
            end
            if (upd_mispred && (perf_mispred != '1)) begin
                perf_mispred <= perf_mispred + CNT_W'(1);
            end
        end
    end

    // Offset bits and the PC bits above the tag never select anything.
    logic unused_bits;
    assign unused_bits = ^{upd_pc, upd_target[1:0]};

endmodule

// File: tb/tb_etcpu_bpred.sv
// Randomized bench for etcpu_bpred against a behavioural table model, plus directed scenarios.
module tb_etcpu_bpred;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lkp_pc;
    logic        lkp_hit, lkp_taken, lkp_hit2, lkp_taken2;
    logic [31:0] lkp_next_pc, lkp_next_pc2;
    logic        upd_vld, upd_taken, upd_mispred, inv, perf_clr;
    logic [31:0] upd_pc, upd_target;
    logic [15:0] perf_br16, perf_mp16;
    logic [1:0]  perf_br2, perf_mp2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    etcpu_bpred u_dut (
        .clk(clk), .rst_n(rst_n), .lkp_pc(lkp_pc), .lkp_hit(lkp_hit),
        .lkp_taken(lkp_taken), .lkp_next_pc(lkp_next_pc), .upd_vld(upd_vld),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispred(upd_mispred), .inv(inv), .perf_clr(perf_clr),
        .perf_branches(perf_br16), .perf_mispred(perf_mp16)
    );

    etcpu_bpred #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .lkp_pc(lkp_pc), .lkp_hit(lkp_hit2),
        .lkp_taken(lkp_taken2), .lkp_next_pc(lkp_next_pc2), .upd_vld(upd_vld),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispred(upd_mispred), .inv(inv), .perf_clr(perf_clr),
        .perf_branches(perf_br2), .perf_mispred(perf_mp2)
    );

    // Reference model: a 16-entry table indexed by word address, 8-bit tag above it.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_ctr   [16];
    logic [31:0] m_tgt   [16];
    int unsigned m_br16, m_mp16, m_br2, m_mp2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return (pc / 64) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 32'h0;
        end
        m_br16 = 0; m_mp16 = 0; m_br2 = 0; m_mp2 = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                                output logic [31:0] npc);
        int unsigned i;
        i   = f_idx(pc);
        hit = m_valid[i] && (m_tag[i] == f_tag(pc));
        tk  = hit && (m_ctr[i] >= 2);
        npc = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic rn, input logic vld, input logic [31:0] pc,
                                input logic tk, input logic [31:0] tgt, input logic mis,
                                input logic iv, input logic clr);
        int unsigned i;
        bit hit;
        if (!rn) begin
            model_reset();
            return;
        end
        i   = f_idx(pc);
        hit = m_valid[i] && (m_tag[i] == f_tag(pc));
        if (iv) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        end else if (vld) begin
            if (hit && tk) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt & 32'hFFFF_FFFC;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = f_tag(pc);
                m_tgt[i]   = tgt & 32'hFFFF_FFFC;
                m_ctr[i]   = 2;
            end
        end
        if (clr) begin
            m_br16 = 0; m_mp16 = 0; m_br2 = 0; m_mp2 = 0;
        end else if (vld) begin
            if (m_br16 < 65535) m_br16++;
            if (m_br2 < 3) m_br2++;
            if (mis && m_mp16 < 65535) m_mp16++;
            if (mis && m_mp2 < 3) m_mp2++;
        end
    endtask

    // One clock: drive, compare both instances against the model, clock, advance the model.
    task automatic step(input logic rn, input logic [31:0] lpc, input logic vld,
                        input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                        input logic mis, input logic iv, input logic clr,
                        output logic hit_seen);
        logic        e_hit, e_tk;
        logic [31:0] e_npc;
        rst_n = rn; lkp_pc = lpc; upd_vld = vld; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_mispred = mis; inv = iv; perf_clr = clr;
        #1;
        model_lookup(lpc, e_hit, e_tk, e_npc);
        chk("hit",      32'(lkp_hit),      32'(e_hit));
        chk("taken",    32'(lkp_taken),    32'(e_tk));
        chk("next_pc",  lkp_next_pc,       e_npc);
        chk("hit_c2",   32'(lkp_hit2),     32'(e_hit));
        chk("next_c2",  lkp_next_pc2,      e_npc);
        chk("perf_br",  32'(perf_br16),    m_br16);
        chk("perf_mp",  32'(perf_mp16),    m_mp16);
        chk("perf_br2", 32'(perf_br2),     m_br2);
        chk("perf_mp2", 32'(perf_mp2),     m_mp2);
        hit_seen = lkp_hit;
        @(posedge clk);
        model_update(rn, vld, upc, tk, tgt, mis, iv, clr);
        @(negedge clk);
    endtask

    // Idle-cycle lookup checked against hand-derived constants.
    task automatic probe(input string name, input logic [31:0] pc, input logic e_hit,
                         input logic e_tk, input logic [31:0] e_npc);
        rst_n = 1'b1; lkp_pc = pc; upd_vld = 1'b0; upd_mispred = 1'b0;
        inv = 1'b0; perf_clr = 1'b0;
        #1;
        chk({name, "_hit"},   32'(lkp_hit),   32'(e_hit));
        chk({name, "_taken"}, 32'(lkp_taken), 32'(e_tk));
        chk({name, "_npc"},   lkp_next_pc,    e_npc);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) pc = pc | ($urandom() & 32'hFFFF_C000);
        if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC | $urandom_range(0, 3);
        return pc;
    endfunction

    initial begin
        logic h;
        rst_n = 1'b0; lkp_pc = '0; upd_vld = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispred = 1'b0; inv = 1'b0; perf_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset discards a concurrent update.
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, h);
        probe("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        chk("rst_perf_br", 32'(perf_br16), 32'd0);

        // Allocate, then walk the counter up to saturation and back down.
        step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, h);
        probe("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        repeat (2) step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, h);
        step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, h);
        probe("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
        step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, h);
        probe("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        repeat (3) step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, h);
        step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, h);
        probe("ctr_floor", 32'h100, 1'b1, 1'b0, 32'h104);

        // Aliasing on index 0: 0x140 has tag 5, 0x100 has tag 4.
        probe("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
        step(1'b1, 32'h0, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, h);
        probe("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        probe("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

        // Same-cycle update and lookup: no bypass.
        step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, h);
        chk("same_cycle_hit", 32'(h), 32'd0);
        probe("same_next", 32'h100, 1'b1, 1'b1, 32'h200);

        // Invalidate wins over a concurrent allocation.
        step(1'b1, 32'h0, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, h);
        probe("inv_a", 32'h100, 1'b0, 1'b0, 32'h104);
        probe("inv_b", 32'h180, 1'b0, 1'b0, 32'h184);
        probe("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Counter saturation on the 2-bit instance, then clear beating an increment.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, h);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, (i != 2), 1'b0, 1'b0, h);
        end
        chk("sat_br2", 32'(perf_br2), 32'd3);
        chk("sat_mp2", 32'(perf_mp2), 32'd3);
        chk("cnt_br16", 32'(perf_br16), 32'd5);
        chk("cnt_mp16", 32'(perf_mp16), 32'd4);
        step(1'b1, 32'h0, 1'b1, 32'h20, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, h);
        chk("clr_br2", 32'(perf_br2), 32'd0);
        chk("clr_mp16", 32'(perf_mp16), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 149) != 0), rand_pc(), ($urandom_range(0, 2) != 0),
                 rand_pc(), $urandom_range(0, 1) == 1, $urandom(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 49) == 0, h);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
